// File: rtl/if_prefetch_queue_if.sv
// Signal bundle between the prefetch queue, the instruction memory, the Mem-stage redirect source and IF/ID.
// The master modport is the prefetch queue side; slave is its environment.
interface if_prefetch_queue_if;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_pc4;
  logic [31:0] out_inst;

  modport master (
    input  redirect, redirect_pc, mem_ack, mem_rdata, out_ready,
    output mem_req, mem_addr, out_valid, out_pc, out_pc4, out_inst
  );

  modport slave (
    output redirect, redirect_pc, mem_ack, mem_rdata, out_ready,
    input  mem_req, mem_addr, out_valid, out_pc, out_pc4, out_inst
  );
endinterface

// File: rtl/if_prefetch_queue.sv
// Instruction prefetch stage: single-outstanding fetch engine feeding a small {pc, pc+4, inst} FIFO
// towards IF/ID, with flush-and-restart on a Mem-stage redirect.
module if_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               Clk,
  input  logic               Reset,
  if_prefetch_queue_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;

  logic [31:0] pc_q   [DEPTH];
  logic [31:0] pc4_q  [DEPTH];
  logic [31:0] inst_q [DEPTH];
  logic [DEPTH-1:0] wr_en;

  logic req;
  logic push;
  logic pop;

  // A redirect suppresses the request, any push and any pop in the same cycle.
  assign req  = ~Reset & (state_q == ST_IDLE) & (count_q < DEPTH_C) & ~bus.redirect;
  assign push = (state_q == ST_WAIT) & bus.mem_ack & ~bus.redirect;
  assign pop  = (count_q != '0) & bus.out_ready & ~bus.redirect;

  assign bus.mem_req   = req;
  assign bus.mem_addr  = fetch_pc_q;
  assign bus.out_valid = (count_q != '0);
  assign bus.out_pc    = pc_q[rd_ptr_q];
  assign bus.out_pc4   = pc4_q[rd_ptr_q];
  assign bus.out_inst  = inst_q[rd_ptr_q];

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    if (bus.redirect) begin
      fetch_pc_d = bus.redirect_pc & 32'hFFFF_FFFC;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      case (state_q)
        ST_WAIT: state_d = bus.mem_ack ? ST_IDLE : ST_DROP;
        ST_DROP: state_d = bus.mem_ack ? ST_IDLE : ST_DROP;
        default: state_d = ST_IDLE;
      endcase
    end else begin
      case (state_q)
        ST_IDLE: if (req) state_d = ST_WAIT;
        ST_WAIT: if (bus.mem_ack) begin
          state_d    = ST_IDLE;
          fetch_pc_d = fetch_pc_q + 32'd4;
        end
        ST_DROP: if (bus.mem_ack) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_wr_en
      assign wr_en[gi] = push & (wr_ptr_q == PW'(gi));
    end
  endgenerate

  // Entries are cleared on reset so the head fields read as zero until the first push.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        pc4_q[i]  <= '0;
        inst_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en[i]) begin
          pc_q[i]   <= fetch_pc_q;
          pc4_q[i]  <= fetch_pc_q + 32'd4;
          inst_q[i] <= bus.mem_rdata;
        end
      end
    end
  end
endmodule
